// File: rtl/fifo_wr_arbiter.sv
// Two-requester write arbiter in front of a FIFO. Grants one requester at a
// time for a burst of up to MAX_BURST words, alternating priority between
// bursts. Words pass straight through; nothing is buffered here.
module fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req,
    input  logic [1:0]            last,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic [DATA_WIDTH-1:0] data1,
    input  logic                  full,
    output logic [1:0]            gnt,
    output logic [1:0]            ack,
    output logic                  wr,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  busy
);

    localparam logic [3:0] MaxBurstW = 4'(MAX_BURST);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic       prio_q, prio_d;
    logic [3:0] cnt_q, cnt_d;

    logic       g;       // granted index, valid in StGrant
    logic       xfer;    // a word is written this cycle
    logic [3:0] cnt_inc;

    assign g       = gnt_q[1];
    assign xfer    = (state_q == StGrant) && req[g] && !full && !reset;
    assign cnt_inc = cnt_q + 4'd1;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            gnt_q   <= 2'b00;
            prio_q  <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: arbitration in idle, burst accounting while granted
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                gnt_d = 2'b00;
                if (req != 2'b00) begin
                    state_d = StGrant;
                    cnt_d   = 4'd0;
                    if (req == 2'b11) gnt_d = prio_q ? 2'b10 : 2'b01;
                    else              gnt_d = req;
                end
            end
            StGrant: begin
                if (!req[g]) begin
                    // Withdrawal ends the burst without a write
                    state_d = StIdle;
                    gnt_d   = 2'b00;
                    prio_d  = ~g;
                end else if (!full) begin
                    cnt_d = cnt_inc;
                    if (last[g] || (cnt_inc == MaxBurstW)) begin
                        state_d = StIdle;
                        gnt_d   = 2'b00;
                        prio_d  = ~g;
                    end
                end
                // full stalls: everything held
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // Outputs: combinational from registered grant, forced quiet during reset
    always_comb begin
        wr     = xfer;
        ack    = xfer ? gnt_q : 2'b00;
        busy   = (state_q == StGrant) && !reset;
        gnt    = reset ? 2'b00 : gnt_q;
        w_data = '0;
        if ((state_q == StGrant) && !reset) begin
            w_data = g ? data1 : data0;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with default parameters (8-bit, burst 4).
module tb_fifo_wr_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [1:0] last;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       full;
    logic [1:0] gnt;
    logic [1:0] ack;
    logic       wr;
    logic [7:0] w_data;
    logic       busy;

    int total = 0;
    int bad   = 0;

    fifo_wr_arbiter #(
        .DATA_WIDTH(8),
        .MAX_BURST (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .last  (last),
        .data0 (data0),
        .data1 (data1),
        .full  (full),
        .gnt   (gnt),
        .ack   (ack),
        .wr    (wr),
        .w_data(w_data),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Check all outputs of one cycle (called 1ns after inputs change)
    task automatic chk_all(input string tag, input logic [1:0] e_gnt, input logic e_wr,
                           input logic [1:0] e_ack, input logic [7:0] e_data,
                           input logic e_busy);
        chk({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
        chk({tag, ".wr"}, 32'(wr), 32'(e_wr));
        chk({tag, ".ack"}, 32'(ack), 32'(e_ack));
        chk({tag, ".wdata"}, 32'(w_data), 32'(e_data));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    endtask

    initial begin
        reset = 1'b1; req = 2'b11; last = 2'b00; data0 = 8'h00; data1 = 8'h00; full = 1'b0;
        cyc();
        #1;
        chk_all("rst", 2'b00, 1'b0, 2'b00, 8'h00, 1'b0);

        // Single requester, three-word packet ending on last
        reset = 1'b0; req = 2'b01; data0 = 8'hA1;
        #1;
        chk_all("single.idle", 2'b00, 1'b0, 2'b00, 8'h00, 1'b0);
        cyc();
        #1;
        chk_all("single.w1", 2'b01, 1'b1, 2'b01, 8'hA1, 1'b1);
        cyc();
        data0 = 8'hA2;
        #1;
        chk_all("single.w2", 2'b01, 1'b1, 2'b01, 8'hA2, 1'b1);
        cyc();
        data0 = 8'hA3; last = 2'b01;
        #1;
        chk_all("single.w3", 2'b01, 1'b1, 2'b01, 8'hA3, 1'b1);
        cyc();
        req = 2'b00; last = 2'b00;
        #1;
        chk_all("single.end", 2'b00, 1'b0, 2'b00, 8'h00, 1'b0);

        // Contention from reset: 0, 1, 0 in bursts of four with one idle between
        reset = 1'b1;
        cyc();
        reset = 1'b0; req = 2'b11;
        for (int r = 0; r < 3; r++) begin
            #1;
            chk_all($sformatf("cont%0d.idle", r), 2'b00, 1'b0, 2'b00, 8'h00, 1'b0);
            cyc();
            for (int k = 0; k < 4; k++) begin
                data0 = 8'h10 + 8'(k);
                data1 = 8'h20 + 8'(k);
                #1;
                if (r == 1)
                    chk_all($sformatf("cont%0d.w%0d", r, k), 2'b10, 1'b1, 2'b10,
                            8'h20 + 8'(k), 1'b1);
                else
                    chk_all($sformatf("cont%0d.w%0d", r, k), 2'b01, 1'b1, 2'b01,
                            8'h10 + 8'(k), 1'b1);
                cyc();
            end
        end

        // Full stall for three cycles after word 2
        reset = 1'b1; req = 2'b00;
        cyc();
        reset = 1'b0; req = 2'b01;
        cyc();
        data0 = 8'h31;
        #1;
        chk_all("stall.w1", 2'b01, 1'b1, 2'b01, 8'h31, 1'b1);
        cyc();
        data0 = 8'h32;
        #1;
        chk_all("stall.w2", 2'b01, 1'b1, 2'b01, 8'h32, 1'b1);
        cyc();
        data0 = 8'h33; full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk_all($sformatf("stall.hold%0d", s), 2'b01, 1'b0, 2'b00, 8'h33, 1'b1);
            cyc();
        end
        full = 1'b0;
        #1;
        chk_all("stall.w3", 2'b01, 1'b1, 2'b01, 8'h33, 1'b1);
        cyc();
        data0 = 8'h34;
        #1;
        chk_all("stall.w4", 2'b01, 1'b1, 2'b01, 8'h34, 1'b1);
        cyc();
        #1;
        chk_all("stall.end", 2'b00, 1'b0, 2'b00, 8'h00, 1'b0);

        // Withdrawal: prio is now 1, requester 1 wins, writes one word, drops req
        req = 2'b11;
        cyc();
        data1 = 8'h41;
        #1;
        chk_all("wd.w1", 2'b10, 1'b1, 2'b10, 8'h41, 1'b1);
        cyc();
        req = 2'b01;
        #1;
        chk_all("wd.drop", 2'b10, 1'b0, 2'b00, 8'h41, 1'b1);
        cyc();
        req = 2'b11;
        #1;
        chk_all("wd.idle", 2'b00, 1'b0, 2'b00, 8'h00, 1'b0);
        cyc();

        // Requester 0 granted (prio 0); last on its first word
        data0 = 8'h45; last = 2'b01;
        #1;
        chk_all("lastfirst.w1", 2'b01, 1'b1, 2'b01, 8'h45, 1'b1);
        cyc();
        last = 2'b00;
        #1;
        chk_all("lastfirst.idle", 2'b00, 1'b0, 2'b00, 8'h00, 1'b0);
        cyc();

        // prio now 1: requester 1 bursts, reset after its second word
        data1 = 8'h51;
        #1;
        chk_all("rstmid.w1", 2'b10, 1'b1, 2'b10, 8'h51, 1'b1);
        cyc();
        data1 = 8'h52;
        #1;
        chk_all("rstmid.w2", 2'b10, 1'b1, 2'b10, 8'h52, 1'b1);
        cyc();
        data1 = 8'h53; reset = 1'b1;
        #1;
        chk_all("rstmid.rst", 2'b00, 1'b0, 2'b00, 8'h00, 1'b0);
        cyc();
        reset = 1'b0;
        #1;
        chk_all("rstmid.idle", 2'b00, 1'b0, 2'b00, 8'h00, 1'b0);
        cyc();
        data0 = 8'h61;
        #1;
        chk_all("rstmid.g0", 2'b01, 1'b1, 2'b01, 8'h61, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
